// File: rtl/riscv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | riscv_pkg : shared memory-access sizes and LSU state encoding           |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_HALF  = 2'd1,
    MEM_WORD  = 2'd2,
    MEM_DWORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic int unsigned size_bytes(input mem_size_t s);
    return 32'd1 << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_lsu_align.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rv_lsu_align : byte-enable generation, write-lane shift, read extract   |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
module rv_lsu_align
  import riscv_pkg::*;
#(
  parameter  int          XLEN  = 32,
  localparam int unsigned NB    = XLEN / 8,
  localparam int          OFF_W = $clog2(XLEN / 8),
  localparam int          SB_W  = $clog2(XLEN)
) (
  input  mem_size_t             size,
  input  logic [OFF_W-1:0]      offset,
  input  logic                  zero_extend,
  input  logic [XLEN-1:0]       wdata,
  input  logic [2*XLEN-1:0]     rdata2,
  output logic [2*NB-1:0]       be2,
  output logic [2*XLEN-1:0]     wdata2,
  output logic [XLEN-1:0]       rd_ext
);

  int unsigned         nbytes;
  int unsigned         nb_eff;
  logic [2*NB-1:0]     mask;
  logic [XLEN-1:0]     raw;
  logic [SB_W-1:0]     sbit;
  logic                fill;

  // Lane view spans two words so a crossing access maps onto both beats.
  always_comb begin
    nbytes = size_bytes(size);
    nb_eff = (nbytes > NB) ? NB : nbytes;
    mask   = '0;
    for (int unsigned b = 0; b < 2 * NB; b++) begin
      mask[b] = (b < nbytes);
    end
    be2    = mask << offset;
    wdata2 = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
    raw    = XLEN'(rdata2 >> {offset, 3'b000});
    sbit   = SB_W'(8 * nb_eff - 1);
    fill   = ~zero_extend & raw[sbit];
    rd_ext = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      rd_ext[b*8 +: 8] = (b < nb_eff) ? raw[b*8 +: 8] : {8{fill}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rv_lsu : load/store unit, one outstanding bus access, request/grant bus |
// | Option : RV_LSU_MISALIGNED_SPLIT_EN splits boundary-crossing accesses   |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module rv_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req,
  input  logic              lsu_wr_en,
  input  mem_size_t         lsu_size,
  input  logic              lsu_zero_extend,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]   lsu_wr_data,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic [XLEN-1:0]   lsu_rd_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN/8-1:0] bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int          OFF_W = $clog2(XLEN / 8);

  lsu_state_t          r_state, w_next;
  logic                r_wr_en, r_zext, r_fault;
  mem_size_t           r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic                r_second, r_beat;
  logic [XLEN-1:0]     r_rdata_lo;
  logic                r_done, r_err;
  logic [XLEN-1:0]     r_rd_data;

  logic                w_accept, w_finish, w_fault, w_dword_bad;
  logic [OFF_W-1:0]    w_in_off;
  int unsigned         w_in_bytes;
  logic [2*NB-1:0]     w_be2;
  logic [2*XLEN-1:0]   w_wdata2, w_merged;
  logic [XLEN-1:0]     w_rd_ext;
  logic [ADDR_W-1:0]   w_base;

  assign lsu_ready   = (r_state == IDLE);
  assign w_accept    = lsu_req && lsu_ready;
  assign w_in_off    = lsu_addr[OFF_W-1:0];
  assign w_in_bytes  = size_bytes(lsu_size);
  assign w_dword_bad = (lsu_size == MEM_DWORD) && (XLEN == 32);

`ifdef RV_LSU_MISALIGNED_SPLIT_EN
  logic w_cross;
  assign w_cross = (32'(w_in_off) + w_in_bytes) > NB;
  assign w_fault = w_dword_bad;

  // Beat 0 returns the low word; it is kept for the merge with beat 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_second <= 1'b0;
      r_beat   <= 1'b0;
    end else if (w_accept) begin
      r_second <= w_cross && !w_dword_bad;
      r_beat   <= 1'b0;
    end else if (r_state == RESP && bus_rvalid && r_second) begin
      r_second   <= 1'b0;
      r_beat     <= 1'b1;
      r_rdata_lo <= bus_rdata;
    end
  end
`else
  logic w_unaligned;
  assign w_unaligned = (32'(w_in_off) & (w_in_bytes - 32'd1)) != 32'd0;
  assign w_fault     = w_dword_bad || w_unaligned;
  assign r_second    = 1'b0;
  assign r_beat      = 1'b0;
  assign r_rdata_lo  = '0;
`endif

  assign w_finish = (r_state == ADDR && r_fault) ||
                    (r_state == RESP && bus_rvalid && !r_second);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_fault   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      r_err   <= w_finish && r_fault;
      if (w_finish && !r_fault && !r_wr_en) begin
        r_rd_data <= w_rd_ext;
      end
      if (w_accept) begin
        r_fault <= w_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr_en <= lsu_wr_en;
      r_size  <= lsu_size;
      r_zext  <= lsu_zero_extend;
      r_addr  <= lsu_addr;
      r_wdata <= lsu_wr_data;
    end
  end

  // A faulted access parks one cycle in ADDR without raising bus_req.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ADDR;
      ADDR:    if (r_fault) w_next = IDLE;
               else if (bus_gnt) w_next = RESP;
      RESP:    if (bus_rvalid) w_next = r_second ? ADDR : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_merged = r_beat ? {bus_rdata, r_rdata_lo} : {{XLEN{1'b0}}, bus_rdata};
  assign w_base   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  rv_lsu_align #(.XLEN(XLEN)) u_align (
    .size        (r_size),
    .offset      (r_addr[OFF_W-1:0]),
    .zero_extend (r_zext),
    .wdata       (r_wdata),
    .rdata2      (w_merged),
    .be2         (w_be2),
    .wdata2      (w_wdata2),
    .rd_ext      (w_rd_ext)
  );

  assign bus_req     = (r_state == ADDR) && !r_fault;
  assign bus_we      = r_wr_en;
  assign bus_addr    = r_beat ? (w_base + ADDR_W'(NB)) : w_base;
  assign bus_be      = r_beat ? w_be2[2*NB-1:NB] : w_be2[NB-1:0];
  assign bus_wdata   = r_beat ? w_wdata2[2*XLEN-1:XLEN] : w_wdata2[XLEN-1:0];
  assign lsu_done    = r_done;
  assign lsu_err     = r_err;
  assign lsu_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_rv_lsu : scoreboard bench for rv_lsu with a word-memory bus model    |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
module tb_rv_lsu;
  import riscv_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              lsu_req, lsu_wr_en, lsu_zero_extend;
  mem_size_t         lsu_size;
  logic [ADDR_W-1:0] lsu_addr;
  logic [XLEN-1:0]   lsu_wr_data;
  logic              lsu_ready, lsu_done, lsu_err;
  logic [XLEN-1:0]   lsu_rd_data;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  rv_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .lsu_req(lsu_req), .lsu_wr_en(lsu_wr_en), .lsu_size(lsu_size),
    .lsu_zero_extend(lsu_zero_extend), .lsu_addr(lsu_addr), .lsu_wr_data(lsu_wr_data),
    .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rd_data(lsu_rd_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic        has_data;
    logic [31:0] data;
    int          done_cyc;
  } res_t;

  beat_t       beat_q[$];
  res_t        res_q[$];
  logic [31:0] mem [logic [31:0]];

  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          gnt_hold = 0, hold_cnt = 0, rv_delay = 0, rv_wait = 0;
  logic        rv_pending = 1'b0;
  logic [31:0] rv_data, exp_rd;
  logic [71:0] snap;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic monitor();
    res_t r;
    if (lsu_done === 1'b1) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", 72'(1), 72'(0));
      end else begin
        r = res_q.pop_front();
        check("lsu_err", 72'(lsu_err), 72'(r.err));
        if (r.has_data) check("lsu_rd_data", 72'(lsu_rd_data), 72'(r.data));
        if (r.done_cyc >= 0) check("done_cycle", 72'(cyc), 72'(r.done_cyc));
        check("ready_in_done", 72'(lsu_ready), 72'(1));
      end
    end
  endtask

  task automatic respond();
    beat_t       b;
    logic [71:0] cur;
    logic [31:0] word;
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom();
    if (rv_pending) begin
      if (rv_wait == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rv_data;
        rv_pending = 1'b0;
      end else begin
        rv_wait--;
      end
    end
    bus_gnt = 1'b0;
    if (bus_req === 1'b1) begin
      cur = {3'b0, bus_we, bus_be, bus_addr, bus_wdata};
      if (hold_cnt > 0) check("hold_stable", cur, snap);
      if (hold_cnt < gnt_hold) begin
        snap = cur;
        hold_cnt++;
      end else begin
        bus_gnt  = 1'b1;
        hold_cnt = 0;
        if (beat_q.size() == 0) begin
          check("unexpected_bus_req", 72'(1), 72'(0));
        end else begin
          b = beat_q.pop_front();
          check("bus_addr", 72'(bus_addr), 72'(b.addr));
          check("bus_be", 72'(bus_be), 72'(b.be));
          check("bus_we", 72'(bus_we), 72'(b.we));
          if (b.we) check("bus_wdata", 72'(bus_wdata & lane_mask(b.be)), 72'(b.wdata & lane_mask(b.be)));
        end
        word = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
        if (bus_we) begin
          for (int i = 0; i < 4; i++) if (bus_be[i]) word[i*8 +: 8] = bus_wdata[i*8 +: 8];
          mem[bus_addr] = word;
        end
        rv_data    = word;
        rv_pending = 1'b1;
        rv_wait    = rv_delay;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    respond();
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input mem_size_t sz, input logic zx, input logic [31:0] a,
                       input logic [31:0] wd, input logic expect_done, input logic err,
                       input logic [31:0] data, input int lat);
    res_t r;
    int   n = 0;
    while (lsu_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 72'(0), 72'(1));
    if (expect_done) begin
      r.err      = err;
      r.has_data = !we;
      r.data     = err ? exp_rd : data;
      r.done_cyc = (lat >= 0) ? cyc + lat : -1;
      if (!we && !err) exp_rd = data;
      res_q.push_back(r);
    end
    lsu_req = 1'b1; lsu_wr_en = we; lsu_size = sz; lsu_zero_extend = zx;
    lsu_addr = a; lsu_wr_data = wd;
    tick();
    lsu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((res_q.size() != 0 || beat_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      check("completion_timeout", 72'(0), 72'(1));
      res_q.delete();
      beat_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; lsu_req = 1'b0; lsu_wr_en = 1'b0; lsu_size = MEM_WORD;
    lsu_zero_extend = 1'b0; lsu_addr = '0; lsu_wr_data = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_rd = 32'h0;
    mem[32'h1000] = 32'hAABBCCDD;
    mem[32'h1004] = 32'h11223344;

    repeat (3) tick();
    check("rst_ready", 72'(lsu_ready), 72'(1));
    check("rst_done", 72'(lsu_done), 72'(0));
    check("rst_err", 72'(lsu_err), 72'(0));
    check("rst_rd_data", 72'(lsu_rd_data), 72'(0));
    check("rst_bus_req", 72'(bus_req), 72'(0));
    reset = 1'b0;
    tick();

    // Aligned loads with sign/zero extension.
    push_beat(32'h1000, 4'hF, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'hAABBCCDD, 3);
    wait_done();
    push_beat(32'h1000, 4'h8, 1'b0, 32'h0);
    issue(1'b0, MEM_BYTE, 1'b0, 32'h1003, 32'h0, 1'b1, 1'b0, 32'hFFFFFFAA, 3);
    wait_done();
    push_beat(32'h1000, 4'h8, 1'b0, 32'h0);
    issue(1'b0, MEM_BYTE, 1'b1, 32'h1003, 32'h0, 1'b1, 1'b0, 32'h000000AA, 3);
    wait_done();
    push_beat(32'h1000, 4'hC, 1'b0, 32'h0);
    issue(1'b0, MEM_HALF, 1'b0, 32'h1002, 32'h0, 1'b1, 1'b0, 32'hFFFFAABB, 3);
    wait_done();
    push_beat(32'h1000, 4'h3, 1'b0, 32'h0);
    issue(1'b0, MEM_HALF, 1'b1, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0000CCDD, 3);
    wait_done();

    // Misaligned accesses.
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
    push_beat(32'h1000, 4'hC, 1'b0, 32'h0);
    push_beat(32'h1004, 4'h3, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1002, 32'h0, 1'b1, 1'b0, 32'h3344AABB, 5);
    wait_done();
    push_beat(32'h1000, 4'h6, 1'b0, 32'h0);
    issue(1'b0, MEM_HALF, 1'b0, 32'h1001, 32'h0, 1'b1, 1'b0, 32'hFFFFBBCC, 3);
    wait_done();
    push_beat(32'h1000, 4'h8, 1'b0, 32'h0);
    push_beat(32'h1004, 4'h1, 1'b0, 32'h0);
    issue(1'b0, MEM_HALF, 1'b0, 32'h1003, 32'h0, 1'b1, 1'b0, 32'h000044AA, 5);
    wait_done();
    push_beat(32'h1000, 4'h6, 1'b1, 32'h00BEEF00);
    issue(1'b1, MEM_HALF, 1'b0, 32'h1001, 32'h0000BEEF, 1'b1, 1'b0, 32'h0, 3);
    wait_done();
    push_beat(32'h1000, 4'hF, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'hAABEEFDD, 3);
    wait_done();
`else
    issue(1'b0, MEM_WORD, 1'b0, 32'h1002, 32'h0, 1'b1, 1'b1, 32'h0, 2);
    wait_done();
    issue(1'b0, MEM_HALF, 1'b0, 32'h1001, 32'h0, 1'b1, 1'b1, 32'h0, 2);
    wait_done();
    issue(1'b1, MEM_HALF, 1'b0, 32'h1001, 32'h0000BEEF, 1'b1, 1'b1, 32'h0, 2);
    wait_done();
`endif

    // Store with grant withheld three cycles, then read back.
    gnt_hold = 3;
    push_beat(32'h1008, 4'hC, 1'b1, 32'hBEEF0000);
    issue(1'b1, MEM_HALF, 1'b0, 32'h100A, 32'h0000BEEF, 1'b1, 1'b0, 32'h0, 6);
    wait_done();
    gnt_hold = 0;
    push_beat(32'h1008, 4'hF, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1008, 32'h0, 1'b1, 1'b0, 32'hBEEF0000, 3);
    // Request held high while busy must not start a second access.
    lsu_req = 1'b1; lsu_addr = 32'h1000; lsu_size = MEM_WORD; lsu_wr_en = 1'b0;
    tick();
    tick();
    lsu_req = 1'b0;
    wait_done();

    // Reset while waiting for the response; the late rvalid must be ignored.
    rv_delay = 3;
    push_beat(32'h1000, 4'hF, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, -1);
    for (int n = 0; n < 20 && beat_q.size() != 0; n++) tick();
    check("reset_test_granted", 72'(beat_q.size()), 72'(0));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("post_reset_ready", 72'(lsu_ready), 72'(1));
    check("post_reset_done", 72'(lsu_done), 72'(0));
    check("post_reset_rd_data", 72'(lsu_rd_data), 72'(0));
    rv_delay = 0;
    exp_rd   = 32'h0;
    push_beat(32'h1004, 4'hF, 1'b0, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'h1004, 32'h0, 1'b1, 1'b0, 32'h11223344, 3);
    wait_done();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
